mem_commit_aligner: RTL and testbench
=====================================

Name: mem_commit_aligner

Overview:
- Sits between the core wrapper's raw trace outputs and the ISA checker's instCommit/mem inputs.
- The core reports each data-memory access in the cycle it happens, which precedes the instruction's commit by a variable number of cycles. This block buffers those access records in order.
- It re-emits each record in the same cycle as the commit of its load/store, so the checker sees commit and memory fields together.
- It flags ordering violations with sticky error bits.

Parameters:
- DEPTH, 4: maximum number of memory records held between access and commit; power of two, at least 2.
- OCC_W, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- in_mem_read_valid  in  1  core load access this cycle
- in_mem_read_addr  in  32  load address
- in_mem_read_memWidth  in  6  load width, one-hot encoded in bytes
- in_mem_read_data  in  32  load data
- in_mem_write_valid  in  1  core store access this cycle
- in_mem_write_addr  in  32  store address
- in_mem_write_memWidth  in  6  store width
- in_mem_write_data  in  32  store data
- in_commit_valid  in  1  instruction retires this cycle
- in_commit_inst  in  32  retiring instruction word
- in_commit_pc  in  32  retiring PC
- out_commit_valid  out  1  registered commit strobe to checker
- out_commit_inst  out  32  registered instruction word
- out_commit_pc  out  32  registered PC
- out_mem_read_valid / out_mem_read_addr / out_mem_read_memWidth / out_mem_read_data  out  1/32/6/32  aligned load record
- out_mem_write_valid / out_mem_write_addr / out_mem_write_memWidth / out_mem_write_data  out  1/32/6/32  aligned store record
- occupancy  out  OCC_W  records currently buffered
- err_underflow  out  1  sticky: load/store committed with no record available
- err_overflow  out  1  sticky: record arrived while buffer full and no pop
- err_protocol  out  1  sticky: record kind mismatched the committing opcode, or read and write arrived in the same cycle

Behaviour:
- Reset, synchronous active-high:
  - All outputs are 0.
  - FIFO pointers and occupancy are cleared.
  - Error flags are cleared.
  - Reset mid-operation discards all buffered records.
- Record format: {is_write, addr[31:0], width[5:0], data[31:0]}, stored in a circular FIFO of DEPTH entries.
  - Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- Push:
  - Exactly one of in_mem_read_valid / in_mem_write_valid is high: push that record.
  - Both high: push nothing and set err_protocol.
- Commit classification uses in_commit_inst[6:0]:
  - 7'b0000011 is LOAD.
  - 7'b0100011 is STORE.
  - Anything else is non-memory.
- Pop: occurs when in_commit_valid is high and the opcode is LOAD or STORE.
  - Head record kind matches the opcode: drive it onto the matching out_mem_* group with valid=1 next cycle; the other group is 0.
  - Head record kind mismatches: the record is still popped, both mem valids are 0, and err_protocol is set.
  - Buffer empty (and no bypass): no pop, both mem valids are 0, and err_underflow is set.
- Latency:
  - All out_* fields are registered, exactly 1 cycle after in_commit_*.
  - When out_commit_valid=0, every out_mem_* field is 0.
  - Non-memory commits drive both mem groups to 0.
- Simultaneous push and pop:
  - A new record is pushed and the head is popped; occupancy is unchanged.
  - This is legal even when full.
  - At occupancy 0, the pushed record is not visible to a same-cycle pop unless MEM_ALIGN_BYPASS_EN is defined.
- Full: a push with occupancy==DEPTH and no pop drops the record and sets err_overflow; the FIFO contents are unchanged.
- Error flags are sticky until reset.
- occupancy reflects the post-update count and is registered.

Optional Feature:
- Macro: MEM_ALIGN_BYPASS_EN.
- Defined: when occupancy==0 and a matching record arrives in the same cycle as a LOAD/STORE commit:
  - The record bypasses the FIFO and appears on out_mem_* next cycle with valid=1.
  - It is not stored, and occupancy stays 0.
  - No error is raised.
- Not defined: that case pushes the record (occupancy becomes 1) and sets err_underflow for the commit.

Test Plan:
- Load at addr 0x100, width 4, data 0xDEADBEEF in cycle 1; LOAD commit (inst 0x0000A083, pc 0x80000000) in cycle 3 -> cycle 4: out_commit_valid=1, out_mem_read_valid=1, addr 0x100, data 0xDEADBEEF, occupancy back to 0.
- Store 0x200 then load 0x300 buffered; commit STORE then LOAD on consecutive cycles -> write record, then read record, emitted in order; no error flags.
- DEPTH=4: five stores with no commits -> occupancy=4, err_overflow=1 after the fifth, first four records are intact on later commits.
- LOAD commit with empty buffer and no same-cycle access -> both mem valids 0 next cycle, err_underflow=1 and stays 1 until reset.
- Buffered write record, then LOAD commit -> err_protocol=1, occupancy decrements, out_mem_read_valid=0.
- Same-cycle load access and LOAD commit at occupancy 0:
  - With MEM_ALIGN_BYPASS_EN: out_mem_read_valid=1, occupancy 0, no errors.
  - Without it: occupancy 1, err_underflow=1.
  - Then assert reset -> all outputs and flags read 0.

Source files
------------

// File: rtl/mem_commit_aligner.sv
// mem_commit_aligner: buffers core memory-access records and re-emits each with its commit; MEM_ALIGN_BYPASS_EN enables same-cycle bypass at empty
module mem_commit_aligner #(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_mem_read_valid,
  input  logic [31:0]      in_mem_read_addr,
  input  logic [5:0]       in_mem_read_memWidth,
  input  logic [31:0]      in_mem_read_data,
  input  logic             in_mem_write_valid,
  input  logic [31:0]      in_mem_write_addr,
  input  logic [5:0]       in_mem_write_memWidth,
  input  logic [31:0]      in_mem_write_data,
  input  logic             in_commit_valid,
  input  logic [31:0]      in_commit_inst,
  input  logic [31:0]      in_commit_pc,
  output logic             out_commit_valid,
  output logic [31:0]      out_commit_inst,
  output logic [31:0]      out_commit_pc,
  output logic             out_mem_read_valid,
  output logic [31:0]      out_mem_read_addr,
  output logic [5:0]       out_mem_read_memWidth,
  output logic [31:0]      out_mem_read_data,
  output logic             out_mem_write_valid,
  output logic [31:0]      out_mem_write_addr,
  output logic [5:0]       out_mem_write_memWidth,
  output logic [31:0]      out_mem_write_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             err_protocol
);
  localparam int AW = $clog2(DEPTH);
  logic [70:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [64:0] cm_q, cm_d;
  logic [70:0] rd_q, rd_d, wr_q, wr_d;
  logic und_q, und_d, ovf_q, ovf_d, prot_q, prot_d;
  logic is_ld, is_st, is_mem, push_req, empty, full, byp, pop, push, match, hit;
  logic [70:0] rec, head, src;
  assign is_ld    = in_commit_inst[6:0] == 7'b0000011;
  assign is_st    = in_commit_inst[6:0] == 7'b0100011;
  assign is_mem   = in_commit_valid & (is_ld | is_st);
  assign push_req = in_mem_read_valid ^ in_mem_write_valid;
  assign rec      = in_mem_write_valid ? {1'b1, in_mem_write_addr, in_mem_write_memWidth, in_mem_write_data}
                                       : {1'b0, in_mem_read_addr, in_mem_read_memWidth, in_mem_read_data};
  assign empty    = occ_q == '0;
  assign full     = occ_q == OCC_W'(DEPTH);
  assign head     = mem_q[rd_ptr_q];
`ifdef MEM_ALIGN_BYPASS_EN
  assign byp      = is_mem & empty & push_req & (in_mem_write_valid == is_st);
`else
  assign byp      = 1'b0;
`endif
  assign pop      = is_mem & ~empty;
  assign match    = head[70] == is_st;
  assign push     = push_req & ~byp & (~full | pop);
  assign hit      = byp | (pop & match);
  assign src      = byp ? rec : head;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    cm_d     = in_commit_valid ? {1'b1, in_commit_inst, in_commit_pc} : '0;
    rd_d     = (hit & is_ld) ? {1'b1, src[69:0]} : '0;
    wr_d     = (hit & is_st) ? {1'b1, src[69:0]} : '0;
    und_d    = und_q | (is_mem & empty & ~byp);
    ovf_d    = ovf_q | (push_req & ~byp & full & ~pop);
    prot_d   = prot_q | (in_mem_read_valid & in_mem_write_valid) | (pop & ~match);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cm_q     <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      und_q    <= 1'b0;
      ovf_q    <= 1'b0;
      prot_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cm_q     <= cm_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
      prot_q   <= prot_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= rec;
  end
  assign {out_commit_valid, out_commit_inst, out_commit_pc} = cm_q;
  assign {out_mem_read_valid, out_mem_read_addr, out_mem_read_memWidth, out_mem_read_data} = rd_q;
  assign {out_mem_write_valid, out_mem_write_addr, out_mem_write_memWidth, out_mem_write_data} = wr_q;
  assign occupancy     = occ_q;
  assign err_underflow = und_q;
  assign err_overflow  = ovf_q;
  assign err_protocol  = prot_q;
endmodule

// File: tb/tb_mem_commit_aligner.sv
// tb_mem_commit_aligner: directed checks of record alignment, overflow, underflow, protocol and reset
module tb_mem_commit_aligner;
  localparam logic [31:0] LD  = 32'h0000A083;
  localparam logic [31:0] ST  = 32'h00112023;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clock = 1'b0, reset = 1'b0;
  logic rv = 1'b0, wv = 1'b0, cv = 1'b0;
  logic [31:0] ra = '0, rdat = '0, wa = '0, wdat = '0, ci = '0, cpc = '0;
  logic [5:0] rw = 6'b000100, ww = 6'b000010;
  logic ocv, orv, owv, e_und, e_ovf, e_prot;
  logic [31:0] oci, opc, ora, ord, owa, owd;
  logic [5:0] orw, oww;
  logic [2:0] occ;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  mem_commit_aligner #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_mem_read_valid(rv), .in_mem_read_addr(ra), .in_mem_read_memWidth(rw), .in_mem_read_data(rdat),
    .in_mem_write_valid(wv), .in_mem_write_addr(wa), .in_mem_write_memWidth(ww), .in_mem_write_data(wdat),
    .in_commit_valid(cv), .in_commit_inst(ci), .in_commit_pc(cpc),
    .out_commit_valid(ocv), .out_commit_inst(oci), .out_commit_pc(opc),
    .out_mem_read_valid(orv), .out_mem_read_addr(ora), .out_mem_read_memWidth(orw), .out_mem_read_data(ord),
    .out_mem_write_valid(owv), .out_mem_write_addr(owa), .out_mem_write_memWidth(oww), .out_mem_write_data(owd),
    .occupancy(occ), .err_underflow(e_und), .err_overflow(e_ovf), .err_protocol(e_prot)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [31:0] a_r, input logic [31:0] d_r,
                     input logic w, input logic [31:0] a_w, input logic [31:0] d_w,
                     input logic c, input logic [31:0] inst, input logic [31:0] pc);
    rv = r; ra = a_r; rdat = d_r; wv = w; wa = a_w; wdat = d_w; cv = c; ci = inst; cpc = pc;
    @(posedge clock);
    #1;
    rv = 1'b0; wv = 1'b0; cv = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_cv"}, {31'd0, ocv}, 0);
    check({tag, "_ci"}, oci, 0);
    check({tag, "_pc"}, opc, 0);
    check({tag, "_rv"}, {31'd0, orv}, 0);
    check({tag, "_ra"}, ora, 0);
    check({tag, "_rd"}, ord, 0);
    check({tag, "_rw"}, {26'd0, orw}, 0);
    check({tag, "_wv"}, {31'd0, owv}, 0);
    check({tag, "_wa"}, owa, 0);
    check({tag, "_wd"}, owd, 0);
    check({tag, "_ww"}, {26'd0, oww}, 0);
    check({tag, "_occ"}, {29'd0, occ}, 0);
    check({tag, "_errs"}, {29'd0, e_und, e_ovf, e_prot}, 0);
  endtask
  initial begin
    do_reset();
    do_reset();
    check_zero("rst");
    // single load aligned two cycles later
    cyc(1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    check("ld_occ1", {29'd0, occ}, 1);
    check("ld_cv_early", {31'd0, ocv}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, LD, 32'h80000000);
    check("ld_cv", {31'd0, ocv}, 1);
    check("ld_ci", oci, LD);
    check("ld_pc", opc, 32'h80000000);
    check("ld_rv", {31'd0, orv}, 1);
    check("ld_ra", ora, 32'h100);
    check("ld_rd", ord, 32'hDEADBEEF);
    check("ld_rw", {26'd0, orw}, 4);
    check("ld_wv", {31'd0, owv}, 0);
    check("ld_occ0", {29'd0, occ}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_cv", {31'd0, ocv}, 0);
    check("idle_rv", {31'd0, orv}, 0);
    // store then load, committed in order
    cyc(0, 0, 0, 1, 32'h200, 32'h11, 0, 0, 0);
    cyc(1, 32'h300, 32'h22, 0, 0, 0, 0, 0, 0);
    check("sl_occ2", {29'd0, occ}, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, ST, 32'h4);
    check("sl_wv", {31'd0, owv}, 1);
    check("sl_wa", owa, 32'h200);
    check("sl_wd", owd, 32'h11);
    check("sl_ww", {26'd0, oww}, 2);
    check("sl_rv0", {31'd0, orv}, 0);
    check("sl_occ1", {29'd0, occ}, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, LD, 32'h8);
    check("sl_rv", {31'd0, orv}, 1);
    check("sl_ra", ora, 32'h300);
    check("sl_rd", ord, 32'h22);
    check("sl_wv0", {31'd0, owv}, 0);
    check("sl_occ0", {29'd0, occ}, 0);
    check("sl_errs", {29'd0, e_und, e_ovf, e_prot}, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, NOP, 32'hC);
    check("nop_cv", {31'd0, ocv}, 1);
    check("nop_mem", {30'd0, orv, owv}, 0);
    // fill past DEPTH
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 32'h400 + 32'(i * 4), 32'(i), 0, 0, 0);
      if (i == 3) check("ovf_pre", {31'd0, e_ovf}, 0);
    end
    check("ovf_occ", {29'd0, occ}, 4);
    check("ovf_flag", {31'd0, e_ovf}, 1);
    cyc(0, 0, 0, 1, 32'h500, 32'h55, 1, ST, 32'h10);
    check("full_pp_wa", owa, 32'h400);
    check("full_pp_wd", owd, 0);
    check("full_pp_occ", {29'd0, occ}, 4);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, ST, 32'h10);
      check("drain_wv", {31'd0, owv}, 1);
      check("drain_wa", owa, 32'h400 + 32'(i * 4));
      check("drain_wd", owd, 32'(i));
      check("drain_occ", {29'd0, occ}, 32'(4 - i));
    end
    cyc(0, 0, 0, 0, 0, 0, 1, ST, 32'h10);
    check("drain_last_wa", owa, 32'h500);
    check("drain_last_wd", owd, 32'h55);
    check("drain_last_occ", {29'd0, occ}, 0);
    check("drain_und", {31'd0, e_und}, 0);
    // underflow
    cyc(0, 0, 0, 0, 0, 0, 1, LD, 32'h20);
    check("und_cv", {31'd0, ocv}, 1);
    check("und_mem", {30'd0, orv, owv}, 0);
    check("und_flag", {31'd0, e_und}, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("und_sticky", {31'd0, e_und}, 1);
    // kind mismatch
    check("prot_pre", {31'd0, e_prot}, 0);
    cyc(0, 0, 0, 1, 32'h600, 32'h66, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, LD, 32'h24);
    check("prot_flag", {31'd0, e_prot}, 1);
    check("prot_occ", {29'd0, occ}, 0);
    check("prot_mem", {30'd0, orv, owv}, 0);
    // same-cycle access and commit at empty
    do_reset();
    check_zero("rst2");
    cyc(1, 32'h700, 32'h77, 0, 0, 0, 1, LD, 32'h28);
`ifdef MEM_ALIGN_BYPASS_EN
    check("byp_rv", {31'd0, orv}, 1);
    check("byp_ra", ora, 32'h700);
    check("byp_occ", {29'd0, occ}, 0);
    check("byp_errs", {29'd0, e_und, e_ovf, e_prot}, 0);
`else
    check("nobyp_rv", {31'd0, orv}, 0);
    check("nobyp_occ", {29'd0, occ}, 1);
    check("nobyp_und", {31'd0, e_und}, 1);
`endif
    do_reset();
    check_zero("rst3");
    // simultaneous read and write access
    cyc(1, 32'h800, 32'h1, 1, 32'h900, 32'h2, 0, 0, 0);
    check("both_prot", {31'd0, e_prot}, 1);
    check("both_occ", {29'd0, occ}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
